x_window_buffer: RTL

- Parametrised, double-buffered (ping-pong) input-activation buffer for the matrix/convolution datapath.
- Accepts packed LOAD_W-bit words over a valid/ready handshake and assembles ROWS rows of ROW_ELEMS elements per bank.
- Serves LANES-wide element windows to the MAC array by window index, with 1-cycle registered latency.
- One bank can fill while the other is read, so the MAC array does not stall between tiles.

---
 rtl/x_buf_pkg.sv | 56 +++++
 rtl/x_win_mux.sv | 41 ++++
 rtl/x_window_buffer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/x_buf_pkg.sv
// Shared derived constants and parameter legality check for the window buffer.
package x_buf_pkg;

    // Elements per load word.
    function automatic int unsigned epw(input int unsigned elem_w, input int unsigned load_w);
        return load_w / elem_w;
    endfunction

    // Load words per row.
    function automatic int unsigned wpr(input int unsigned elem_w, input int unsigned load_w,
                                        input int unsigned row_elems);
        return row_elems / epw(elem_w, load_w);
    endfunction

    // Load words per bank.
    function automatic int unsigned nwords(input int unsigned elem_w, input int unsigned load_w,
                                           input int unsigned rows, input int unsigned row_elems);
        return rows * wpr(elem_w, load_w, row_elems);
    endfunction

    // Windows per row.
    function automatic int unsigned wprw(input int unsigned row_elems, input int unsigned lanes,
                                         input int unsigned win_step);
        return (row_elems - lanes) / win_step + 1;
    endfunction

    // Windows per bank.
    function automatic int unsigned nwin(input int unsigned rows, input int unsigned row_elems,
                                         input int unsigned lanes, input int unsigned win_step);
        return rows * wprw(row_elems, lanes, win_step);
    endfunction

    // Index width, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when the parameter set describes a buildable buffer.
    function automatic bit params_ok(input int unsigned elem_w, input int unsigned load_w,
                                     input int unsigned rows, input int unsigned row_elems,
                                     input int unsigned lanes, input int unsigned win_step);
        if (elem_w == 0 || load_w == 0 || rows == 0 || row_elems == 0 ||
            lanes == 0 || win_step == 0)
            return 1'b0;
        if ((load_w % elem_w) != 0)
            return 1'b0;
        if (((row_elems * elem_w) % load_w) != 0)
            return 1'b0;
        if (lanes > row_elems)
            return 1'b0;
        if (((row_elems - lanes) % win_step) != 0)
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/x_win_mux.sv
// Combinational window extraction from one flat bank.
//   bank  : ROWS*ROW_ELEMS elements, element i at bits [i*ELEM_W +: ELEM_W]
//   sel   : window index
//   win_c : LANES elements, lane 0 in the MSBs
//   oor_c : sel is not a valid window index
module x_win_mux
    import x_buf_pkg::*;
#(
    parameter int unsigned ELEM_W    = 8,
    parameter int unsigned ROWS      = 3,
    parameter int unsigned ROW_ELEMS = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned WIN_STEP  = 2,
    parameter int unsigned SEL_W     = 4
) (
    input  logic [ROWS*ROW_ELEMS*ELEM_W-1:0] bank,
    input  logic [SEL_W-1:0]                 sel,
    output logic [LANES*ELEM_W-1:0]          win_c,
    output logic                             oor_c
);

    localparam int unsigned WPRW = wprw(ROW_ELEMS, LANES, WIN_STEP);
    localparam int unsigned NWIN = ROWS * WPRW;

    // One comparator per legal window; no match means out of range.
    always_comb begin
        win_c = '0;
        oor_c = 1'b1;
        for (int s = 0; s < int'(NWIN); s++) begin
            if (sel == SEL_W'(s)) begin
                oor_c = 1'b0;
                for (int l = 0; l < int'(LANES); l++) begin
                    win_c[(int'(LANES) - 1 - l)*int'(ELEM_W) +: ELEM_W] =
                        bank[((s / int'(WPRW))*int'(ROW_ELEMS) +
                              (s % int'(WPRW))*int'(WIN_STEP) + l)*int'(ELEM_W) +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: rtl/x_window_buffer.sv
// Ping-pong input-activation buffer: fills one bank from LOAD_W words while the
// other bank serves LANES-wide windows to the MAC array.
//   clk, rst (async, active-low), flush (sync clear)
//   in_valid/in_ready/in_data : load word handshake, element 0 in MSBs
//   load_done                 : pulse after a bank's last word is accepted
//   bank_valid                : read bank is full
//   rd_req/rd_sel             : window read, result one cycle later
//   rd_release                : hand the read bank back to the loader
//   win_valid/win_data/win_err: registered read response
module x_window_buffer
    import x_buf_pkg::*;
#(
    parameter int unsigned ELEM_W    = 8,
    parameter int unsigned LOAD_W    = 32,
    parameter int unsigned ROWS      = 3,
    parameter int unsigned ROW_ELEMS = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned WIN_STEP  = 2,
    localparam int unsigned SEL_W    = idx_w(nwin(ROWS, ROW_ELEMS, LANES, WIN_STEP))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LOAD_W-1:0]       in_data,
    output logic                    load_done,
    output logic                    bank_valid,
    input  logic                    rd_req,
    input  logic [SEL_W-1:0]        rd_sel,
    input  logic                    rd_release,
    output logic                    win_valid,
    output logic [LANES*ELEM_W-1:0] win_data,
    output logic                    win_err
);

    localparam int unsigned EPW    = epw(ELEM_W, LOAD_W);
    localparam int unsigned NWORDS = nwords(ELEM_W, LOAD_W, ROWS, ROW_ELEMS);
    localparam int unsigned CNT_W  = idx_w(NWORDS);
    localparam int unsigned BANK_W = ROWS * ROW_ELEMS * ELEM_W;
    localparam int unsigned WIN_W  = LANES * ELEM_W;

    // Refuse to elaborate an inconsistent parameter set.
    if (!params_ok(ELEM_W, LOAD_W, ROWS, ROW_ELEMS, LANES, WIN_STEP)) begin : g_bad_params
        $fatal(1, "x_window_buffer: illegal parameter combination");
    end

    logic [LOAD_W-1:0] words_q [2][NWORDS];
    logic [BANK_W-1:0] flat    [2];
    logic [1:0]        full_q, full_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win_valid_d, win_err_d, load_done_d;
    logic [WIN_W-1:0]  win_data_d;
    logic              accept_c, last_c, rel_c, hit_c;
    logic [WIN_W-1:0]  win_c;
    logic              oor_c;

    assign in_ready   = !full_q[wr_ptr_q];
    assign bank_valid = full_q[rd_ptr_q];

    // Word w element e lands at flat element w*EPW+e; rows are contiguous words.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar w = 0; w < int'(NWORDS); w++) begin : g_word
            for (genvar e = 0; e < int'(EPW); e++) begin : g_elem
                assign flat[b][(w*int'(EPW) + e)*int'(ELEM_W) +: ELEM_W] =
                    words_q[b][w][(int'(EPW) - 1 - e)*int'(ELEM_W) +: ELEM_W];
            end
        end
    end

    x_win_mux #(
        .ELEM_W   (ELEM_W),
        .ROWS     (ROWS),
        .ROW_ELEMS(ROW_ELEMS),
        .LANES    (LANES),
        .WIN_STEP (WIN_STEP),
        .SEL_W    (SEL_W)
    ) u_mux (
        .bank (rd_ptr_q ? flat[1] : flat[0]),
        .sel  (rd_sel),
        .win_c(win_c),
        .oor_c(oor_c)
    );

    // Next-state for pointers, full flags and read response.
    always_comb begin
        accept_c    = in_valid && in_ready;
        last_c      = accept_c && (cnt_q == CNT_W'(NWORDS - 1));
        rel_c       = rd_release && bank_valid;
        hit_c       = rd_req && bank_valid;
        full_d      = full_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        load_done_d = last_c;
        win_valid_d = 1'b0;
        win_err_d   = 1'b0;
        win_data_d  = win_data;

        if (accept_c)
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        // Loader and reader never own the same bank, so both updates can apply.
        if (last_c) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (rel_c) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = !rd_ptr_q;
        end
        if (hit_c) begin
            if (oor_c) begin
                win_err_d  = 1'b1;
                win_data_d = '0;
            end else begin
                win_valid_d = 1'b1;
                win_data_d  = win_c;
            end
        end

        if (flush) begin
            full_d      = '0;
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            cnt_d       = '0;
            load_done_d = 1'b0;
            win_valid_d = 1'b0;
            win_err_d   = 1'b0;
            win_data_d  = '0;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            load_done <= 1'b0;
            win_valid <= 1'b0;
            win_err   <= 1'b0;
            win_data  <= '0;
        end else begin
            full_q    <= full_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            load_done <= load_done_d;
            win_valid <= win_valid_d;
            win_err   <= win_err_d;
            win_data  <= win_data_d;
        end
    end

    // Bank storage, written one load word at a time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < int'(NWORDS); w++)
                    words_q[b][w] <= '0;
        end else if (flush) begin
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < int'(NWORDS); w++)
                    words_q[b][w] <= '0;
        end else if (accept_c) begin
            words_q[wr_ptr_q][cnt_q] <= in_data;
        end
    end

endmodule
